// File: rtl/qspi_mem_responder.sv
// SPI/QSPI flash-like target: oversamples C/S/DQ on clk, decodes opcode/address/dummy
// phases and serves reads from / commits page programs to an internal byte RAM.
module qspi_mem_responder #(
  parameter int unsigned AW       = 12,
  parameter logic [23:0] JEDEC_ID = 24'h20BA18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C,
  input  logic       S,
  inout  wire  [3:0] DQio,
  output logic       selected,
  output logic [7:0] last_cmd,
  output logic       wel
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_RDSR,
    ST_RDID,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  state_t        state;
  logic          c_s1, c_s2, c_prev;
  logic          s_s1, s_s2;
  logic [3:0]    dq_s1, dq_s2;
  logic          c_rise, c_fall;

  logic [4:0]    bit_cnt;
  logic [22:0]   sh_in;
  logic [AW-1:0] ptr;
  logic          quad;
  logic [3:0]    oe;
  logic [3:0]    dq_o;
  logic [7:0]    tx_sh;
  logic [2:0]    tx_cnt;
  logic [1:0]    id_idx;

  logic          rd_req;
  logic [7:0]    ram_q;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    mem [DEPTH];

  logic [23:0]   addr_c;
  logic [7:0]    cmd_c;
  logic [7:0]    wbyte_c;
  logic [7:0]    tx_src_c;
  logic [7:0]    tx_cur_c;

  // Two-flop synchronizers plus previous-C register for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      c_s1   <= 1'b0;
      c_s2   <= 1'b0;
      c_prev <= 1'b0;
      s_s1   <= 1'b1;
      s_s2   <= 1'b1;
      dq_s1  <= 4'h0;
      dq_s2  <= 4'h0;
    end else begin
      c_s1   <= C;
      c_s2   <= c_s1;
      c_prev <= c_s2;
      s_s1   <= S;
      s_s2   <= s_s1;
      dq_s1  <= DQio;
      dq_s2  <= dq_s1;
    end
  end

  assign c_rise = c_s2 & ~c_prev;
  assign c_fall = ~c_s2 & c_prev;

  // Incoming serial/quad shift views and the byte about to be shifted out
  always_comb begin
    addr_c   = {sh_in, dq_s2[0]};
    cmd_c    = addr_c[7:0];
    wbyte_c  = quad ? {sh_in[3:0], dq_s2} : addr_c[7:0];
    tx_src_c = 8'h00;
    case (state)
      ST_RDATA: tx_src_c = ram_q;
      ST_RDSR:  tx_src_c = {6'b0, wel, 1'b0};
      ST_RDID: begin
        case (id_idx)
          2'd0:    tx_src_c = JEDEC_ID[23:16];
          2'd1:    tx_src_c = JEDEC_ID[15:8];
          2'd2:    tx_src_c = JEDEC_ID[7:0];
          default: tx_src_c = 8'h00;
        endcase
      end
      default: tx_src_c = 8'h00;
    endcase
    tx_cur_c = (tx_cnt == 3'd0) ? tx_src_c : tx_sh;
  end

  // Frame state machine; a synchronized S high always wins over a C edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      selected <= 1'b0;
      last_cmd <= 8'h00;
      wel      <= 1'b0;
      bit_cnt  <= 5'd0;
      sh_in    <= 23'd0;
      ptr      <= '0;
      quad     <= 1'b0;
      oe       <= 4'h0;
      dq_o     <= 4'h0;
      tx_sh    <= 8'h00;
      tx_cnt   <= 3'd0;
      id_idx   <= 2'd0;
      rd_req   <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'h00;
    end else begin
      selected <= ~s_s2;
      rd_req   <= 1'b0;
      wr_en    <= 1'b0;
      if (s_s2) begin
        if (state == ST_WDATA) wel <= 1'b0;
        state <= ST_IDLE;
        oe    <= 4'h0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_CMD;
            bit_cnt <= 5'd0;
            quad    <= 1'b0;
            tx_cnt  <= 3'd0;
            id_idx  <= 2'd0;
          end

          ST_CMD: if (c_rise) begin
            sh_in   <= addr_c[22:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              last_cmd <= cmd_c;
              bit_cnt  <= 5'd0;
              case (cmd_c)
                8'h06: begin wel <= 1'b1; state <= ST_IGNORE; end
                8'h04: begin wel <= 1'b0; state <= ST_IGNORE; end
                8'h05: state <= ST_RDSR;
                8'h9F: state <= ST_RDID;
                8'h03, 8'h6B, 8'h02, 8'h32: state <= ST_ADDR;
                default: state <= ST_IGNORE;
              endcase
            end
          end

          ST_ADDR: if (c_rise) begin
            sh_in   <= addr_c[22:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              ptr     <= AW'(addr_c);
              rd_req  <= 1'b1;
              bit_cnt <= 5'd0;
              case (last_cmd)
                8'h03: begin state <= ST_RDATA; quad <= 1'b0; end
                8'h6B: begin state <= ST_DUMMY; quad <= 1'b1; end
                8'h02, 8'h32: begin
                  quad  <= (last_cmd == 8'h32);
                  state <= wel ? ST_WDATA : ST_IGNORE;
                end
                default: state <= ST_IGNORE;
              endcase
            end
          end

          ST_DUMMY: if (c_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              state   <= ST_RDATA;
            end
          end

          ST_RDATA, ST_RDSR, ST_RDID: if (c_fall) begin
            if (quad) begin
              dq_o   <= tx_cur_c[7:4];
              oe     <= 4'hF;
              tx_sh  <= {tx_cur_c[3:0], 4'h0};
              tx_cnt <= (tx_cnt == 3'd0) ? 3'd1 : 3'd0;
            end else begin
              dq_o   <= {2'b00, tx_cur_c[7], 1'b0};
              oe     <= 4'b0010;
              tx_sh  <= {tx_cur_c[6:0], 1'b0};
              tx_cnt <= tx_cnt + 3'd1;
            end
            // New byte just started: advance source and prefetch the following byte
            if (tx_cnt == 3'd0) begin
              if (state == ST_RDATA) begin
                ptr    <= ptr + AW'(1);
                rd_req <= 1'b1;
              end
              if (state == ST_RDID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end
          end

          ST_WDATA: if (c_rise) begin
            sh_in   <= quad ? {sh_in[18:0], dq_s2} : addr_c[22:0];
            bit_cnt <= bit_cnt + 5'd1;
            if ((quad && bit_cnt == 5'd1) || (!quad && bit_cnt == 5'd7)) begin
              bit_cnt <= 5'd0;
              wr_en   <= 1'b1;
              wr_addr <= ptr;
              wr_data <= wbyte_c;
              ptr     <= {ptr[AW-1:8], ptr[7:0] + 8'd1};
            end
          end

          default: ;
        endcase
      end
    end
  end

  // Byte RAM: contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_req) ram_q <= mem[ptr];
  end

  for (genvar i = 0; i < 4; i++) begin : g_dq
    assign DQio[i] = oe[i] ? dq_o[i] : 1'bz;
  end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Self-checking bench for qspi_mem_responder: directed frames plus randomized
// program/read-back, checked against a byte-array flash model via a scoreboard.
module tb_qspi_mem_responder;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          HALF  = 8;

  logic       clk = 1'b0;
  logic       reset, C, S;
  logic [3:0] tb_dq, tb_oe;
  wire  [3:0] dq;
  logic       selected, wel;
  logic [7:0] last_cmd;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_bus
    assign dq[i] = tb_oe[i] ? tb_dq[i] : 1'bz;
    pullup (dq[i]);
  end

  qspi_mem_responder #(.AW(AW), .JEDEC_ID(24'h20BA18)) dut (
    .clk(clk), .reset(reset), .C(C), .S(S), .DQio(dq),
    .selected(selected), .last_cmd(last_cmd), .wel(wel)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem_m [DEPTH];
  bit         valid_m [DEPTH];
  bit         wel_m;
  logic [7:0] exp_q [$];
  int         rd_mode = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: assembles bytes seen on the bus at C rises and compares to the scoreboard
  always @(posedge C) begin
    if (rd_mode == 0) begin
      mon_cnt = 0;
    end else begin
      if (rd_mode == 1) begin
        mon_byte = {mon_byte[6:0], dq[1]};
        mon_cnt  = mon_cnt + 1;
      end else begin
        mon_byte = {mon_byte[3:0], dq};
        mon_cnt  = mon_cnt + 4;
      end
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_byte: got %0h with no expected byte queued", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rd_byte", 32'(mon_byte), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cycle_c();
    wclk(HALF); C = 1'b1;
    wclk(HALF); C = 1'b0;
  endtask

  task automatic sbit(input bit b);
    tb_oe = 4'b0001;
    tb_dq = {3'b000, b};
    cycle_c();
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sbit(b[i]);
  endtask

  task automatic saddr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) sbit(a[i]);
  endtask

  task automatic qbyte(input logic [7:0] b);
    tb_oe = 4'hF;
    tb_dq = b[7:4]; cycle_c();
    tb_dq = b[3:0]; cycle_c();
  endtask

  task automatic start_frame();
    S = 1'b0;
    wclk(8);
  endtask

  task automatic stop_frame();
    tb_oe = 4'h0;
    wclk(16);
    S = 1'b1;
    wclk(12);
  endtask

  task automatic read_clocks(input int mode, input int nbytes);
    tb_oe   = 4'h0;
    rd_mode = mode;
    repeat (nbytes * ((mode == 1) ? 8 : 2)) cycle_c();
    rd_mode = 0;
  endtask

  task automatic do_simple(input logic [7:0] op);
    start_frame(); sbyte(op); stop_frame();
    if (op == 8'h06) wel_m = 1'b1;
    if (op == 8'h04) wel_m = 1'b0;
    check("wel_after_op", 32'(wel), 32'(wel_m));
  endtask

  task automatic do_rdsr();
    start_frame(); sbyte(8'h05);
    exp_q.push_back({6'b0, wel_m, 1'b0});
    exp_q.push_back({6'b0, wel_m, 1'b0});
    read_clocks(1, 2);
    stop_frame();
  endtask

  task automatic do_program(input bit q, input int unsigned addr, input logic [7:0] data [$],
                            input int partial);
    int unsigned a;
    start_frame();
    sbyte(q ? 8'h32 : 8'h02);
    saddr(24'(addr));
    foreach (data[i]) begin
      if (q) qbyte(data[i]);
      else   sbyte(data[i]);
    end
    for (int i = 0; i < partial; i++) sbit(i[0]);
    stop_frame();
    if (wel_m) begin
      foreach (data[i]) begin
        a = ((addr % DEPTH) / 256) * 256 + ((addr % 256) + i) % 256;
        mem_m[a]   = data[i];
        valid_m[a] = 1'b1;
      end
      wel_m = 1'b0;
    end
    check("wel_after_prog", 32'(wel), 32'(wel_m));
  endtask

  task automatic do_read(input bit fast, input int unsigned addr, input int n);
    start_frame();
    sbyte(fast ? 8'h6B : 8'h03);
    saddr(24'(addr));
    for (int i = 0; i < n; i++) exp_q.push_back(mem_m[(addr + i) % DEPTH]);
    if (fast) begin
      tb_oe = 4'h0;
      repeat (8) cycle_c();
      read_clocks(2, n);
    end else begin
      read_clocks(1, n);
    end
    stop_frame();
    check("dq_released_after_read", 32'(dq), 32'hF);
  endtask

  initial begin
    int          bad;
    int unsigned addr;
    int          len, n;
    bit          q;
    logic [7:0]  d [$];

    reset = 1'b1; S = 1'b1; C = 1'b0; tb_oe = 4'h0; tb_dq = 4'h0; wel_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;
    wclk(5);
    reset = 1'b0;
    wclk(3);
    check("reset_selected", 32'(selected), 32'h0);
    check("reset_wel", 32'(wel), 32'h0);
    check("reset_last_cmd", 32'(last_cmd), 32'h0);
    check("reset_dq", 32'(dq), 32'hF);

    // Read ID, with a fourth byte past the ID
    start_frame();
    check("selected_in_frame", 32'(selected), 32'h1);
    sbyte(8'h9F);
    exp_q.push_back(8'h20); exp_q.push_back(8'hBA);
    exp_q.push_back(8'h18); exp_q.push_back(8'h00);
    read_clocks(1, 4);
    stop_frame();
    check("rdid_dq_released", 32'(dq), 32'hF);
    check("rdid_last_cmd", 32'(last_cmd), 32'h9F);
    check("selected_after_frame", 32'(selected), 32'h0);

    // Program with and without WEL
    do_simple(8'h06);
    d = '{8'h3C}; do_program(1'b0, 32'h10, d, 0);
    d = '{8'hA5}; do_program(1'b0, 32'h10, d, 0);
    do_read(1'b0, 32'h10, 1);
    do_simple(8'h06);
    do_rdsr();
    d = '{8'hA5}; do_program(1'b0, 32'h10, d, 0);
    do_read(1'b0, 32'h10, 1);
    do_rdsr();
    do_simple(8'h06);
    d = '{8'h99}; do_program(1'b0, 32'h201, d, 0);

    // Quad program across the page end, then quad fast read
    do_simple(8'h06);
    d = '{8'h11, 8'h22, 8'h33}; do_program(1'b1, 32'hFE, d, 0);
    do_read(1'b1, 32'hFE, 2);
    do_read(1'b0, 32'h000, 1);

    // Linear read wraps at the top of the RAM
    do_simple(8'h06);
    d = '{8'h77}; do_program(1'b0, 32'hFFF, d, 0);
    do_read(1'b0, 32'hFFF, 2);

    // Aborted program: partial second byte discarded
    do_simple(8'h06);
    d = '{8'h5A}; do_program(1'b0, 32'h200, d, 4);
    do_read(1'b0, 32'h200, 2);

    // WREN then WRDI
    do_simple(8'h06);
    do_simple(8'h04);

    // Unknown opcode: bus must stay released
    start_frame();
    sbyte(8'hAB);
    tb_oe = 4'h0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      wclk(HALF); if (dq != 4'hF) bad++;
      C = 1'b1;
      wclk(HALF); if (dq != 4'hF) bad++;
      C = 1'b0;
    end
    stop_frame();
    check("ignore_undriven", 32'(bad), 32'h0);
    check("ignore_last_cmd", 32'(last_cmd), 32'hAB);

    // Randomized program / read-back
    for (int it = 0; it < 8; it++) begin
      len  = int'($urandom_range(1, 6));
      addr = $urandom_range(0, 15) * 256 + $urandom_range(0, 256 - len);
      q    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) do_simple(8'h06);
      d = {};
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      do_program(q, addr, d, int'($urandom_range(0, 1)) * 3);
      n = 0;
      while (n < len && valid_m[(addr + n) % DEPTH]) n++;
      if (n > 0) do_read(1'($urandom_range(0, 1)), addr, n);
      if ($urandom_range(0, 1) == 1) do_rdsr();
    end

    // Reset mid-frame while driving Read ID data
    do_simple(8'h06);
    start_frame();
    sbyte(8'h9F);
    tb_oe = 4'h0;
    repeat (4) cycle_c();
    wclk(4);
    reset = 1'b1;
    wclk(2);
    check("midreset_dq_released", 32'(dq), 32'hF);
    check("midreset_wel", 32'(wel), 32'h0);
    check("midreset_last_cmd", 32'(last_cmd), 32'h0);
    reset = 1'b0;
    wel_m = 1'b0;
    S = 1'b1;
    wclk(12);
    do_rdsr();

    wclk(8);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
